// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues PC-ordered requests to a one-cycle memory,
// buffers returned words in a prefetch FIFO, and restarts on a writeback redirect.
module fetch_prefetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic [DATA_W-1:0]          imem_rdata,
  input  logic                       imem_rvalid,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [DATA_W-1:0]          if_instr,
  output logic [ADDR_W-1:0]          if_pc_next,
  output logic [$clog2(DEPTH):0]     if_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_addr;
  logic              inflight;
  logic              kill;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pcn_q   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    credit_used;
  logic              grant;
  logic              inflight_next;
  logic              push;
  logic              pop;

  // A request is only issued when the FIFO has room for it plus any word in flight.
  always_comb begin
    credit_used   = {1'b0, count} + (CNT_W + 1)'(inflight);
    imem_req      = rst_n & ~redirect & (credit_used < (CNT_W + 1)'(DEPTH));
    grant         = imem_req & imem_gnt;
    inflight_next = grant;
    push          = imem_rvalid & inflight & ~kill & ~redirect;
    if_valid      = (count != '0) & ~redirect;
    pop           = if_valid & if_ready;
  end

  assign imem_addr  = fetch_pc;
  assign if_instr   = instr_q[rd_ptr];
  assign if_pc_next = pcn_q[rd_ptr];
  assign if_count   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      issued_addr <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pcn_q[i]   <= '0;
      end
    end else begin
      inflight <= inflight_next;
      if (grant) begin
        fetch_pc    <= fetch_pc + 1'b1;
        issued_addr <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        kill     <= inflight_next;
      end else begin
        // issued_addr still holds the previous cycle's grant here, matching the returning word.
        if (push) begin
          instr_q[wr_ptr] <= imem_rdata;
          pcn_q[wr_ptr]   <= issued_addr + 1'b1;
          wr_ptr          <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        kill <= kill & inflight & ~imem_rvalid;
      end
    end
  end

endmodule
